// File: rtl/cb_instr_rom_pkg.sv
// Core-bus types shared by the instruction ROM and its response buffer.
package cb_instr_rom_pkg;

    typedef logic [31:0] cb_addr_t;
    typedef logic [31:0] cb_data_t;
    typedef logic [2:0]  cb_size_t;
    typedef logic [3:0]  cb_strobe_t;

    typedef enum logic [1:0] {
        CB_OKAY   = 2'b00,
        CB_EXOKAY = 2'b01,
        CB_SLVERR = 2'b10,
        CB_DECERR = 2'b11
    } cb_resp_t;

    // Every channel uses valid/ready: a beat transfers on the rising edge where
    // both are high; a source holds valid and payload stable until that edge.
    typedef struct packed {
        logic       wr_addr_valid;
        cb_addr_t   wr_addr;
        cb_size_t   wr_size;
        logic       wr_valid;
        cb_data_t   wr_data;
        cb_strobe_t wr_strobe;
        logic       wr_resp_ready;
        logic       rd_addr_valid;
        cb_addr_t   rd_addr;
        cb_size_t   rd_size;
        logic       rd_ready;
    } s_cb_mosi_t;

    typedef struct packed {
        logic     wr_addr_ready;
        logic     wr_ready;
        logic     wr_resp_valid;
        cb_resp_t wr_resp;
        logic     rd_addr_ready;
        logic     rd_valid;
        cb_data_t rd_data;
        cb_resp_t rd_resp;
    } s_cb_miso_t;

    typedef struct packed {
        cb_resp_t resp;
        cb_data_t data;
    } s_cb_rd_resp_t;

endpackage

// File: rtl/cb_instr_rom_fifo.sv
// Generic show-ahead FIFO: data_o presents the oldest entry whenever not empty.
module cb_instr_rom_fifo #(
    parameter int SLOTS = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       write_i,
    input  logic                       read_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(SLOTS+1)-1:0] ocup_o
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(SLOTS + 1);

    logic [WIDTH-1:0] slots_q [SLOTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_read;
    logic             do_write;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o  = (count == '0);
    assign full_o   = (count == CW'(SLOTS));
    assign ocup_o   = count;
    assign data_o   = slots_q[rd_ptr];
    // A read in the same cycle frees the slot, so a full FIFO may also accept.
    assign do_read  = read_i & ~empty_o;
    assign do_write = write_i & (~full_o | do_read);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= next_ptr(wr_ptr);
            if (do_read)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_write) - CW'(do_read);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) slots_q[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/cb_instr_rom.sv
// Read-only core-bus instruction memory: fixed-latency, in-order responses with
// a response buffer sized to the outstanding-read limit.
module cb_instr_rom
    import cb_instr_rom_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_KB     = 16,
    parameter int          RD_LATENCY = 1,
    parameter int          MAX_OT_TXN = 4,
    parameter string       INIT_FILE  = ""
) (
    input  logic       clk,
    input  logic       rst,
    input  s_cb_mosi_t cb_mosi_i,
    output s_cb_miso_t cb_miso_o
);

    localparam int              DEPTH     = MEM_KB * 256;
    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [32:0]     MEM_BYTES = 33'(MEM_KB) << 10;
    localparam int              OTW       = $clog2(MAX_OT_TXN) + 1;
    localparam logic [OTW-1:0]  OT_MAX    = OTW'(MAX_OT_TXN);
    localparam int              RW        = $bits(s_cb_rd_resp_t);

    logic [31:0] mem [DEPTH];

    initial begin
        assert (MAX_OT_TXN >= 1) else $fatal(1, "MAX_OT_TXN must be >= 1");
        assert (RD_LATENCY >= 1 && RD_LATENCY <= 4) else $fatal(1, "RD_LATENCY must be 1..4");
        assert (MEM_KB >= 1) else $fatal(1, "MEM_KB must be >= 1");
        assert (({1'b0, BASE_ADDR} + MEM_BYTES) <= 33'h1_0000_0000)
            else $fatal(1, "BASE_ADDR + memory size wraps the address space");
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    logic            rst_q;
    logic [OTW-1:0]  ot_cnt;
    logic            addr_ready;
    logic            accept;
    logic            consume;
    logic [31:0]     offset;
    logic            in_range;
    logic [IDX_W-1:0] word_idx;
    s_cb_rd_resp_t   dec;
    logic            fifo_wr;
    s_cb_rd_resp_t   fifo_wdata;
    logic [RW-1:0]   fifo_rdata;
    s_cb_rd_resp_t   head;
    logic            fifo_empty;
    logic            fifo_full;
    logic [$clog2(MAX_OT_TXN+1)-1:0] fifo_ocup;

    // Holds address ready low for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_q <= 1'b1;
        else     rst_q <= 1'b0;
    end

    assign addr_ready = ~rst_q & (ot_cnt < OT_MAX);
    assign accept     = cb_mosi_i.rd_addr_valid & addr_ready;
    assign consume    = ~fifo_empty & cb_mosi_i.rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ot_cnt <= '0;
        else     ot_cnt <= ot_cnt + OTW'(accept) - OTW'(consume);
    end

    assign offset   = cb_mosi_i.rd_addr - BASE_ADDR;
    assign in_range = (cb_mosi_i.rd_addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    always_comb begin
        dec      = '0;
        dec.resp = in_range ? CB_OKAY : CB_SLVERR;
        if (in_range) dec.data = mem[word_idx];
    end

    // Decode is the first latency stage; the remaining stages are registers.
    generate
        if (RD_LATENCY == 1) begin : g_direct
            assign fifo_wr    = accept;
            assign fifo_wdata = dec;
        end else begin : g_pipe
            logic          pipe_v [RD_LATENCY-1];
            s_cb_rd_resp_t pipe_d [RD_LATENCY-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipe_v[i] <= 1'b0;
                        pipe_d[i] <= '0;
                    end
                end else begin
                    pipe_v[0] <= accept;
                    pipe_d[0] <= dec;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipe_v[i] <= pipe_v[i-1];
                        pipe_d[i] <= pipe_d[i-1];
                    end
                end
            end

            assign fifo_wr    = pipe_v[RD_LATENCY-2];
            assign fifo_wdata = pipe_d[RD_LATENCY-2];
        end
    endgenerate

    cb_instr_rom_fifo #(
        .SLOTS(MAX_OT_TXN),
        .WIDTH(RW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (1'b0),
        .write_i (fifo_wr),
        .read_i  (consume),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ocup_o  (fifo_ocup)
    );

    assign head = s_cb_rd_resp_t'(fifo_rdata);

    always_comb begin
        cb_miso_o               = '0;
        cb_miso_o.rd_addr_ready = addr_ready;
        cb_miso_o.rd_valid      = ~fifo_empty;
        if (!fifo_empty) begin
            cb_miso_o.rd_data = head.data;
            cb_miso_o.rd_resp = head.resp;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{cb_mosi_i, offset[1:0], offset[31:IDX_W+2], fifo_full, fifo_ocup};

endmodule
